// File: rtl/mem_arb2_if.sv
// Signal bundle tying the debug-UART master (m0), the CPU master (m1), mem_arb2 and the word memory.
interface mem_arb2_if;
   logic [31:0] m0_adr;
   logic [31:0] m0_wdata;
   logic        m0_rw;
   logic        m0_op;
   logic [31:0] m0_rdata;
   logic        m0_rdy;
   logic        m0_err;

   logic [31:0] m1_adr;
   logic [31:0] m1_wdata;
   logic        m1_rw;
   logic        m1_op;
   logic [31:0] m1_rdata;
   logic        m1_rdy;
   logic        m1_err;

   logic [31:0] s_adr;
   logic [31:0] s_wdata;
   logic        s_rw;
   logic        s_op;
   logic [31:0] s_rdata;
   logic        s_rdy;

   logic [1:0]  grant;
   logic        busy;

   // Arbiter view: drives the memory request and the master-side responses.
   modport master (
      input  m0_adr, m0_wdata, m0_rw, m0_op,
      output m0_rdata, m0_rdy, m0_err,
      input  m1_adr, m1_wdata, m1_rw, m1_op,
      output m1_rdata, m1_rdy, m1_err,
      output s_adr, s_wdata, s_rw, s_op,
      input  s_rdata, s_rdy,
      output grant, busy
   );

   // Environment view: requesting masters plus the memory responder.
   modport slave (
      output m0_adr, m0_wdata, m0_rw, m0_op,
      input  m0_rdata, m0_rdy, m0_err,
      output m1_adr, m1_wdata, m1_rw, m1_op,
      input  m1_rdata, m1_rdy, m1_err,
      input  s_adr, s_wdata, s_rw, s_op,
      output s_rdata, s_rdy,
      input  grant, busy
   );
endinterface

// File: rtl/mem_arb2.sv
// Two-master word-memory arbiter; s_op rises the cycle after a request is sampled, losers wait on m_op,
// slave stalls are bounded by a TIMEOUT watchdog. `define MEM_ARB_RR_EN selects round-robin over fixed m0 priority.
module mem_arb2 #(
   parameter int unsigned TIMEOUT  = 1023,
   parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
   input  logic       clk,
   input  logic       n_reset,
   mem_arb2_if.master bus
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_GRANT,
      ST_RELEASE
   } state_t;

   typedef struct packed {
      logic [31:0] adr;
      logic [31:0] wdata;
      logic        rw;
   } req_t;

   localparam bit          TMO_EN   = (TIMEOUT != 0);
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

   state_t           r_state, w_state;
   req_t             r_req, w_req;
   logic             r_sop, w_sop;
   logic [15:0]      r_cnt, w_cnt;
   logic [1:0]       r_grant, w_grant;
   logic             r_busy, w_busy;
   logic [1:0][31:0] r_rdata, w_rdata;
   logic [1:0]       r_rdy, w_rdy;
   logic [1:0]       r_err, w_err;

   logic             w_idx;
   logic             w_tmo;
   logic             w_done;
   logic             w_pick_m1;
   req_t             w_m0_req, w_m1_req;

   assign w_idx    = r_grant[1];
   assign w_tmo    = TMO_EN && !bus.s_rdy && (r_cnt == TMO_LAST);
   assign w_done   = (r_state == ST_GRANT) && (bus.s_rdy || w_tmo);
   assign w_m0_req = '{adr: bus.m0_adr, wdata: bus.m0_wdata, rw: bus.m0_rw};
   assign w_m1_req = '{adr: bus.m1_adr, wdata: bus.m1_wdata, rw: bus.m1_rw};

`ifdef MEM_ARB_RR_EN
   // Remembers who was served last; reset value makes m0 win the first tie.
   logic r_last_m1;

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_last_m1 <= 1'b1;
      end else if (w_done) begin
         r_last_m1 <= w_idx;
      end
   end

   assign w_pick_m1 = (bus.m0_op && bus.m1_op) ? ~r_last_m1 : ~bus.m0_op;
`else
   assign w_pick_m1 = ~bus.m0_op;
`endif

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_state <= ST_IDLE;
         r_req   <= '{adr: 32'd0, wdata: 32'd0, rw: 1'b1};
         r_sop   <= 1'b0;
         r_cnt   <= 16'd0;
         r_grant <= 2'b00;
         r_busy  <= 1'b0;
         r_rdata <= '0;
         r_rdy   <= 2'b00;
         r_err   <= 2'b00;
      end else begin
         r_state <= w_state;
         r_req   <= w_req;
         r_sop   <= w_sop;
         r_cnt   <= w_cnt;
         r_grant <= w_grant;
         r_busy  <= w_busy;
         r_rdata <= w_rdata;
         r_rdy   <= w_rdy;
         r_err   <= w_err;
      end
   end

   always_comb begin
      w_state = r_state;
      w_req   = r_req;
      w_sop   = r_sop;
      w_cnt   = r_cnt;
      w_grant = r_grant;
      w_rdata = r_rdata;
      w_rdy   = r_rdy;
      w_err   = r_err;
      case (r_state)
         ST_IDLE: begin
            if (bus.m0_op || bus.m1_op) begin
               w_req   = w_pick_m1 ? w_m1_req : w_m0_req;
               w_sop   = 1'b1;
               w_grant = w_pick_m1 ? 2'b10 : 2'b01;
               w_cnt   = 16'd0;
               w_state = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (bus.s_rdy) begin
               w_sop = 1'b0;
               if (r_req.rw) begin
                  w_rdata[w_idx] = bus.s_rdata;
               end
               w_rdy[w_idx] = 1'b1;
               w_err[w_idx] = 1'b0;
               w_state      = ST_RELEASE;
            end else if (w_tmo) begin
               w_sop = 1'b0;
               if (r_req.rw) begin
                  w_rdata[w_idx] = ERR_DATA;
               end
               w_rdy[w_idx] = 1'b1;
               w_err[w_idx] = 1'b1;
               w_state      = ST_RELEASE;
            end else if (r_cnt != 16'hFFFF) begin
               w_cnt = r_cnt + 16'd1;
            end
         end
         ST_RELEASE: begin
            w_rdy   = 2'b00;
            w_err   = 2'b00;
            w_grant = 2'b00;
            w_state = ST_IDLE;
         end
         default: begin
            w_state = ST_IDLE;
         end
      endcase
      w_busy = (w_state != ST_IDLE);
   end

   assign bus.s_adr    = r_req.adr;
   assign bus.s_wdata  = r_req.wdata;
   assign bus.s_rw     = r_req.rw;
   assign bus.s_op     = r_sop;
   assign bus.grant    = r_grant;
   assign bus.busy     = r_busy;
   assign bus.m0_rdata = r_rdata[0];
   assign bus.m0_rdy   = r_rdy[0];
   assign bus.m0_err   = r_err[0];
   assign bus.m1_rdata = r_rdata[1];
   assign bus.m1_rdy   = r_rdy[1];
   assign bus.m1_err   = r_err[1];

endmodule
